// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding,
// line idle level and frame-length helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Frame length in bit periods for the default 8N1 configuration.
  localparam int FRAME_BITS = 1 + 8 + 0 + 1;

  function automatic int frame_bits(input int data_w, input int parity_en, input int stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: restarts from 0 on request and wraps after
// CLKS_PER_BIT cycles, flagging the final cycle of each bit with bit_tick.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  output logic [CNT_W-1:0] count,
  output logic             bit_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  assign bit_tick = (count == LAST);

  // Wrapping on bit_tick keeps consecutive bits exactly CLKS_PER_BIT apart.
  always_ff @(posedge clk) begin
    if (rst || restart || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a 1-cycle-latency FIFO and serializes each as a UART
// frame: start bit, LSB-first data, optional parity, one or two stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output logic [15:0]       frames_sent
);

  import uart_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic ODD_SENSE = (PARITY_ODD != 0);

  state_t              state_reg;
  logic [DATA_W-1:0]   shift_reg;
  logic                parity_reg;
  logic [IDX_W-1:0]    bit_idx_reg;
  logic [CNT_W-1:0]    count;
  logic                bit_tick;
  logic                restart;

  // Timer is held at zero until START, so START begins on a clean bit boundary.
  assign restart = (state_reg == IDLE) || (state_reg == WAIT);

  // Read strobe is decoded from state so the FIFO sees it in the same cycle.
  assign fifo_rd = (state_reg == IDLE) && en && !fifo_empty && !rst;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .count    (count),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      bit_idx_reg <= '0;
      tx          <= IDLE_LEVEL;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      frames_sent <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (fifo_rd) begin
            state_reg <= WAIT;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          shift_reg  <= fifo_data;
          parity_reg <= (^fifo_data) ^ ODD_SENSE;
          tx         <= 1'b0;
          state_reg  <= START;
        end
        START: begin
          if (bit_tick) begin
            tx          <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            bit_idx_reg <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == LAST_DATA) begin
              bit_idx_reg <= '0;
              if (PARITY_EN != 0) begin
                tx        <= parity_reg;
                state_reg <= PARITY;
              end else begin
                tx        <= IDLE_LEVEL;
                state_reg <= STOP;
              end
            end else begin
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            tx          <= IDLE_LEVEL;
            bit_idx_reg <= '0;
            state_reg   <= STOP;
          end
        end
        STOP: begin
          // Raised one cycle early so the registered pulse lands on the final stop cycle.
          if (bit_idx_reg == LAST_STOP && count == PRE_LAST) begin
            tx_done <= 1'b1;
          end
          if (bit_tick) begin
            if (bit_idx_reg == LAST_STOP) begin
              bit_idx_reg <= '0;
              busy        <= 1'b0;
              frames_sent <= frames_sent + 16'd1;
              state_reg   <= IDLE;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          tx        <= IDLE_LEVEL;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
